// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_t : burst FSM states (IDLE waits for a burst decision, STREAM pops
//             and sends the latched burst).
//   clog2   : ceiling log2 used to size counters from parameters.
package fifo_burst_reader_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while (result < 32 && (64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_axis_out.sv
// Single-stage AXI-Stream output register carrying data and last.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture data_in/last_in and raise tvalid
//   data_in       : word to present on the stream
//   last_in       : final-beat flag for data_in
//   tready        : downstream ready
//   tdata, tvalid, tlast : registered stream outputs
// Outputs hold while tvalid=1 and tready=0; the owner only asserts load
// when the register is empty or being drained in the same cycle.
module axis_out_reg #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  last_in,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  output logic                  tlast
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tdata  <= data_in;
      tvalid <= 1'b1;
      tlast  <= last_in;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side consumer for the async count FIFO. Pops words in fixed-length
// bursts and sends each burst as one AXI-Stream packet (tlast on the final
// beat). Short bursts go out on idle timeout or on flush request.
// Ports:
//   clk, rst        : FIFO read clock, synchronous active-high reset
//   enable          : permits new bursts to start
//   flush           : one-cycle request to drain all residual data
//   fifo_rd_data    : first-word-fall-through head word
//   fifo_empty      : FIFO empty flag
//   fifo_count      : read-domain occupancy (ADDR_WIDTH+1 bits)
//   fifo_rd_en      : pop strobe
//   m_axis_*        : AXI-Stream master (tdata/tvalid/tready/tlast)
//   busy            : burst in progress or beat pending
//   flush_done      : one-cycle pulse when a flush completes
//   bursts_sent     : completed-burst counter, wraps
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned BURST_LEN      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  flush_done,
  output logic [15:0]           bursts_sent
);

  localparam int unsigned CW     = ADDR_WIDTH + 1;
  localparam int unsigned TW_RAW = clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TW     = (TW_RAW == 0) ? 1 : TW_RAW;
  localparam logic [CW-1:0] BL     = CW'(BURST_LEN);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit            T_ON   = (TIMEOUT_CYCLES != 0);

  state_t        state, state_next;
  logic [CW-1:0] pops_left;
  logic [CW-1:0] burst_len;
  logic [TW-1:0] tcnt;
  logic          flush_pending;
  logic          start;
  logic          expired;
  logic          partial;
  logic          pop;
  logic          last_done;

  always_comb begin
    partial   = (fifo_count != '0) && (fifo_count < BL);
    expired   = T_ON && (tcnt == T_LAST);
    last_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    pop       = (state == STREAM) && (pops_left != '0) && !fifo_empty &&
                (!m_axis_tvalid || m_axis_tready);
  end

  // Burst decision: a full burst whenever enough words are present,
  // otherwise a short burst of everything present on flush or timeout.
  always_comb begin
    start     = 1'b0;
    burst_len = '0;
    if (state == IDLE && enable && !m_axis_tvalid) begin
      if (fifo_count >= BL) begin
        start     = 1'b1;
        burst_len = BL;
      end else if (fifo_count != '0 && (flush_pending || expired)) begin
        start     = 1'b1;
        burst_len = fifo_count;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)     state_next = STREAM;
      STREAM:  if (last_done) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pops_left     <= '0;
      tcnt          <= '0;
      flush_pending <= 1'b0;
      bursts_sent   <= '0;
    end else begin
      if (start)    pops_left <= burst_len;
      else if (pop) pops_left <= pops_left - 1'b1;

      // Saturates at the expiry value so a burst held off by enable=0
      // still sees the timeout once enable returns.
      if (start || fifo_count == '0)
        tcnt <= '0;
      else if (T_ON && state == IDLE && partial && !expired)
        tcnt <= tcnt + 1'b1;

      if (flush_done) flush_pending <= 1'b0;
      else if (flush) flush_pending <= 1'b1;

      if (last_done) bursts_sent <= bursts_sent + 16'd1;
    end
  end

  always_comb begin
    fifo_rd_en = pop;
    busy       = (state != IDLE) || m_axis_tvalid;
    flush_done = flush_pending && (state == IDLE) && !m_axis_tvalid &&
                 (fifo_count == '0);
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_axis_out (
    .clk    (clk),
    .rst    (rst),
    .load   (pop),
    .data_in(fifo_rd_data),
    .last_in(pops_left == CW'(1)),
    .tready (m_axis_tready),
    .tdata  (m_axis_tdata),
    .tvalid (m_axis_tvalid),
    .tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BL = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, flush, tready;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [AW:0]   count;
  logic          rd_en, tvalid, tlast, busy, flush_done;
  logic [DW-1:0] tdata;
  logic [15:0]   bursts_sent;

  // Second instance with the timeout disabled, fed a constant 3-word FIFO.
  logic [DW-1:0] b_rd_data;
  logic          b_empty;
  logic [AW:0]   b_count;
  logic          b_rd_en, b_tvalid, b_tlast, b_busy, b_flush_done;
  logic [DW-1:0] b_tdata;
  logic [15:0]   b_bursts;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_rd_data(rd_data), .fifo_empty(empty), .fifo_count(count),
    .fifo_rd_en(rd_en), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .busy(busy),
    .flush_done(flush_done), .bursts_sent(bursts_sent)
  );

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT_CYCLES(0)
  ) dut_no_timeout (
    .clk(clk), .rst(rst), .enable(1'b1), .flush(1'b0),
    .fifo_rd_data(b_rd_data), .fifo_empty(b_empty), .fifo_count(b_count),
    .fifo_rd_en(b_rd_en), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(1'b1), .m_axis_tlast(b_tlast), .busy(b_busy),
    .flush_done(b_flush_done), .bursts_sent(b_bursts)
  );

  // Behavioural FIFO and scoreboard state.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] inflight[$];
  int            pkt_lens[$];
  int            cur_len, model_bursts, n_beats, fd_count, total_pushed;
  int            n_checks = 0;
  int            n_fail   = 0;

  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic          s_rd_en, s_tvalid, s_tlast, s_busy, s_hs;
  logic [DW-1:0] s_tdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic update_pins();
    empty   = (fq.size() == 0);
    count   = (AW+1)'(fq.size());
    rd_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    total_pushed++;
    update_pins();
  endtask

  // One clock cycle: sample mid-cycle, check the protocol rules and the
  // scoreboard, then apply the FIFO pop that the posedge performed.
  task automatic cycle();
    logic          p_pop, p_rst;
    logic [DW-1:0] w;
    #1;
    s_rd_en  = rd_en;
    s_tvalid = tvalid;
    s_tdata  = tdata;
    s_tlast  = tlast;
    s_busy   = busy;
    s_hs     = tvalid && tready && !rst;
    if (!rst) begin
      if (tvalid && !tready) chk("pop_during_stall", rd_en, 0);
      if (prev_stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, prev_data);
        chk("hold_last", tlast, prev_last);
      end
      if (s_hs) begin
        if (inflight.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_source: beat 0x%0h sent with no popped word outstanding", tdata);
        end else begin
          chk("beat_data", tdata, inflight.pop_front());
        end
        n_beats++;
        cur_len++;
        if (tlast) begin
          pkt_lens.push_back(cur_len);
          cur_len = 0;
          model_bursts++;
        end
      end
      if (flush_done) fd_count++;
    end
    chk("no_timeout_no_pop", b_rd_en, 0);
    prev_stall = tvalid && !tready && !rst;
    prev_data  = tdata;
    prev_last  = tlast;
    p_pop = rd_en;
    p_rst = rst;
    @(negedge clk);
    if (p_pop && fq.size() != 0) begin
      w = fq.pop_front();
      if (!p_rst) inflight.push_back(w);
    end
    if (p_rst) begin
      inflight.delete();
      cur_len    = 0;
      prev_stall = 1'b0;
    end
    update_pins();
  endtask

  task automatic reset_all();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; tready = 1'b1;
    fq.delete();
    update_pins();
    cycle();
    cycle();
    rst = 1'b0;
    inflight.delete();
    pkt_lens.delete();
    cur_len = 0; model_bursts = 0; n_beats = 0; fd_count = 0; total_pushed = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    #1;
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_tlast"}, tlast, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flush_done"}, flush_done, 0);
    chk({tag, "_bursts"}, bursts_sent, 0);
  endtask

  typedef struct {
    int unsigned nwords;
    bit          do_flush;
    bit [3:0]    ready_pat;
    int unsigned len0;
    int unsigned len1;
    int unsigned npkts;
    int unsigned exp_fd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, gap, lens_bad, sum;
    bit seen_last;

    vecs[0] = '{nwords: 8,  do_flush: 0, ready_pat: 4'b1111, len0: 8, len1: 0, npkts: 1, exp_fd: 0};
    vecs[1] = '{nwords: 8,  do_flush: 0, ready_pat: 4'b1001, len0: 8, len1: 0, npkts: 1, exp_fd: 0};
    vecs[2] = '{nwords: 5,  do_flush: 1, ready_pat: 4'b1111, len0: 5, len1: 0, npkts: 1, exp_fd: 1};
    vecs[3] = '{nwords: 12, do_flush: 1, ready_pat: 4'b1111, len0: 8, len1: 4, npkts: 2, exp_fd: 1};
    vecs[4] = '{nwords: 16, do_flush: 0, ready_pat: 4'b1111, len0: 8, len1: 8, npkts: 2, exp_fd: 0};
    vecs[5] = '{nwords: 3,  do_flush: 0, ready_pat: 4'b1011, len0: 3, len1: 0, npkts: 1, exp_fd: 0};
    vecs[6] = '{nwords: 0,  do_flush: 1, ready_pat: 4'b1111, len0: 0, len1: 0, npkts: 0, exp_fd: 1};

    b_rd_data = 16'hBEEF; b_empty = 1'b0; b_count = 5'd3;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;

    @(negedge clk);
    reset_all();
    check_outputs_zero("reset");

    // Table-driven scenarios.
    for (int i = 0; i < 7; i++) begin
      reset_all();
      for (int unsigned k = 0; k < vecs[i].nwords; k++)
        push(16'((i << 8) + 16'h10 + k));
      if (vecs[i].do_flush) begin
        flush = 1'b1; cycle(); flush = 1'b0;
      end
      enable = 1'b1;
      for (int c = 0; c < 120; c++) begin
        tready = vecs[i].ready_pat[c % 4];
        cycle();
      end
      tready = 1'b1;
      chk($sformatf("v%0d_npkts", i), pkt_lens.size(), vecs[i].npkts);
      chk($sformatf("v%0d_len0", i), (pkt_lens.size() > 0) ? pkt_lens[0] : 0, vecs[i].len0);
      chk($sformatf("v%0d_len1", i), (pkt_lens.size() > 1) ? pkt_lens[1] : 0, vecs[i].len1);
      chk($sformatf("v%0d_bursts", i), bursts_sent, vecs[i].npkts);
      chk($sformatf("v%0d_flush_done", i), fd_count, vecs[i].exp_fd);
      chk($sformatf("v%0d_drained", i), fq.size(), 0);
    end

    // Full-burst latency and tlast placement.
    reset_all();
    for (int k = 0; k < 8; k++) push(16'(16'h10 + k));
    enable = 1'b1;
    cycle();
    chk("lat_c0_rd_en", s_rd_en, 0);
    chk("lat_c0_tvalid", s_tvalid, 0);
    cycle();
    chk("lat_c1_rd_en", s_rd_en, 1);
    chk("lat_c1_tvalid", s_tvalid, 0);
    cycle();
    chk("lat_c2_tvalid", s_tvalid, 1);
    chk("lat_c2_tdata", s_tdata, 16'h10);
    chk("lat_c2_tlast", s_tlast, 0);
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (s_hs) chk("full_tlast_pos", s_tlast, (s_tdata == 16'h17));
    end
    chk("full_bursts", bursts_sent, 1);

    // Timeout: 3 words, first pop on the cycle after the 16th qualifying one.
    reset_all();
    for (int k = 0; k < 3; k++) push(16'(16'h40 + k));
    enable = 1'b1;
    first = -1;
    for (int c = 0; c < 40 && first < 0; c++) begin
      cycle();
      if (s_rd_en) first = c;
    end
    chk("timeout_first_pop", first, 16);

    // Back-to-back: exactly one non-busy cycle between the two packets.
    reset_all();
    for (int k = 0; k < 16; k++) push(16'(16'h80 + k));
    enable = 1'b1;
    gap = -1;
    seen_last = 0;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (seen_last && gap < 0 && s_busy) gap = c;
      if (s_hs && s_tlast && !seen_last) begin seen_last = 1; first = c; end
    end
    chk("b2b_idle_gap", (gap < 0) ? 32'hFFFF : gap - first - 1, 1);
    chk("b2b_bursts", bursts_sent, 2);

    // Reset at beat 3 aborts the burst on the next edge.
    reset_all();
    for (int k = 0; k < 8; k++) push(16'(16'hA0 + k));
    enable = 1'b1;
    for (int c = 0; c < 40 && n_beats < 3; c++) cycle();
    chk("rst_reached_beat3", n_beats, 3);
    rst = 1'b1;
    cycle();
    check_outputs_zero("midrst");
    rst = 1'b0;

    // enable low at beat 3: the burst completes, no new one starts.
    reset_all();
    for (int k = 0; k < 16; k++) push(16'(16'hC0 + k));
    enable = 1'b1;
    for (int c = 0; c < 40 && n_beats < 3; c++) cycle();
    chk("en_reached_beat3", n_beats, 3);
    enable = 1'b0;
    for (int c = 0; c < 60; c++) cycle();
    chk("en_npkts", pkt_lens.size(), 1);
    chk("en_len", (pkt_lens.size() > 0) ? pkt_lens[0] : 0, 8);
    chk("en_left_in_fifo", fq.size(), 8);
    chk("en_bursts", bursts_sent, 1);

    // Randomized traffic against the scoreboard.
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      if (fq.size() < 16 && $urandom_range(0, 1) == 1)
        push(16'($urandom));
      tready = ($urandom_range(0, 9) < 7);
      enable = ($urandom_range(0, 19) != 0);
      flush  = ($urandom_range(0, 99) == 0);
      cycle();
    end
    flush = 1'b0; enable = 1'b1; tready = 1'b1;
    cycle();
    flush = 1'b1; cycle(); flush = 1'b0;
    for (int c = 0; c < 200; c++) cycle();
    lens_bad = 0;
    sum = 0;
    foreach (pkt_lens[k]) begin
      if (pkt_lens[k] < 1 || pkt_lens[k] > BL) lens_bad++;
      sum += pkt_lens[k];
    end
    chk("rand_len_range", lens_bad, 0);
    chk("rand_all_words_sent", sum, total_pushed);
    chk("rand_fifo_empty", fq.size(), 0);
    chk("rand_inflight_empty", inflight.size(), 0);
    chk("rand_bursts", bursts_sent, model_bursts & 32'hFFFF);
    chk("no_timeout_bursts", b_bursts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
